reversing_bits_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational bit reverser. Reverses a DATA_WIDTH word at one of three granularities (bit, nibble, byte) or passes it through unchanged. Uses a valid/ready handshake with a 2-stage registered pipeline. Sits on a streaming datapath between producer and consumer blocks that both apply backpressure.

---
 rtl/reversing_bits_pipe.sv | 205 ++++++++++++++++++++
 tb/tb_reversing_bits_pipe.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reversing_bits_pipe.sv
// ============================================================================
// reversing_bits_pipe
// ----------------------------------------------------------------------------
// Purpose:
//   Two-stage pipelined word reverser for a streaming datapath. Each word is
//   reversed at the granularity selected by its own mode:
//     00 : bit reverse     out[i]        = in[W-1-i]
//     01 : nibble reverse  nibble k out  = nibble (W/4-1-k) in
//     10 : byte reverse    byte k out    = byte (W/8-1-k) in (endian swap)
//     11 : pass-through    out           = in
//   Sustains one word per cycle. A word offered in the cycle that ends with
//   its accepting edge is on dout two cycles later.
//
// Parameters:
//   DATA_WIDTH : word width in bits (multiple of 8, at least 8)
//   CNT_WIDTH  : width of the completed-transfer counter (statistics build)
//
// Ports:
//   clk        in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   din        in   input word
//   din_mode   in   reverse mode, travels with din
//   din_valid  in   din/din_mode valid
//   din_ready  out  block accepts din this cycle
//   dout       out  reversed word
//   dout_valid out  dout valid
//   dout_ready in   consumer accepts dout this cycle
//   xfer_count out  completed output transfers (REV_STATS_EN builds only)
//
// Build option:
//   REV_STATS_EN : when defined, adds the xfer_count port and its counter.
//                  Without it the port and counter do not exist; all other
//                  behaviour is identical.
// ============================================================================
module reversing_bits_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [1:0]            din_mode,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready
`ifdef REV_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0]  xfer_count
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    generate
        if ((DATA_WIDTH < 8) || ((DATA_WIDTH % 8) != 0)) begin : g_bad_width
            $error("reversing_bits_pipe: DATA_WIDTH must be a multiple of 8 and at least 8");
        end
        if (CNT_WIDTH < 1) begin : g_bad_cnt_width
            $error("reversing_bits_pipe: CNT_WIDTH must be at least 1");
        end
    endgenerate

    localparam int NIBBLES = DATA_WIDTH / 4;
    localparam int BYTES   = DATA_WIDTH / 8;

    localparam logic [1:0] MODE_BIT    = 2'b00;
    localparam logic [1:0] MODE_NIBBLE = 2'b01;
    localparam logic [1:0] MODE_BYTE   = 2'b10;
    localparam logic [1:0] MODE_PASS   = 2'b11;

    // ------------------------------------------------------------------------
    // Reverse helpers. Each one is a pure rewiring of the input bits.
    // ------------------------------------------------------------------------
    function automatic logic [DATA_WIDTH-1:0] rev_bits(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            r[i] = w[DATA_WIDTH-1-i];
        end
        return r;
    endfunction

    // Nibble order flips; the four bits inside each nibble keep their order.
    function automatic logic [DATA_WIDTH-1:0] rev_nibbles(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            r[4*k +: 4] = w[4*(NIBBLES-1-k) +: 4];
        end
        return r;
    endfunction

    // Byte order flips (endian swap); bits inside each byte keep their order.
    function automatic logic [DATA_WIDTH-1:0] rev_bytes(input logic [DATA_WIDTH-1:0] w);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < BYTES; k++) begin
            r[8*k +: 8] = w[8*(BYTES-1-k) +: 8];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high. A sender holds its word stable while valid=1 and ready=0.
    // Ready is produced combinationally from the downstream side so a stage
    // that is emptying in this cycle can accept in the same cycle: no bubbles.
    // ------------------------------------------------------------------------
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [1:0]            s1_mode;

    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    logic                  s1_ready;
    logic                  s2_ready;
    logic                  in_xfer;
    logic                  s1_to_s2;
    logic [DATA_WIDTH-1:0] s1_rev;

    always_comb begin
        s2_ready = !s2_valid || dout_ready;
        s1_ready = !s1_valid || s2_ready;
    end

    assign din_ready = s1_ready;
    assign in_xfer   = din_valid && s1_ready;
    assign s1_to_s2  = s1_valid && s2_ready;

    // Reverse is applied between the stages using the mode that was captured
    // alongside the word, so consecutive words may each use a different mode.
    always_comb begin
        s1_rev = s1_data;
        case (s1_mode)
            MODE_BIT:    s1_rev = rev_bits(s1_data);
            MODE_NIBBLE: s1_rev = rev_nibbles(s1_data);
            MODE_BYTE:   s1_rev = rev_bytes(s1_data);
            MODE_PASS:   s1_rev = s1_data;
            default:     s1_rev = s1_data;
        endcase
    end

    // ------------------------------------------------------------------------
    // Stage 1: captures din/din_mode on an input transfer.
    // Whenever S1 may change (it is empty or its word moves on), its valid
    // simply takes din_valid; otherwise it holds.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= 2'b00;
        end else begin
            if (s1_ready) begin
                s1_valid <= din_valid;
            end
            if (in_xfer) begin
                s1_data <= din;
                s1_mode <= din_mode;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: holds the reversed word presented on dout. Data only loads
    // when a real word arrives, so dout keeps its last value while empty.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (s2_ready) begin
                s2_valid <= s1_valid;
            end
            if (s1_to_s2) begin
                s2_data <= s1_rev;
            end
        end
    end

    assign dout       = s2_data;
    assign dout_valid = s2_valid;

`ifdef REV_STATS_EN
    // ------------------------------------------------------------------------
    // Completed-transfer counter; wraps naturally at 2^CNT_WIDTH.
    // ------------------------------------------------------------------------
    logic out_xfer;
    assign out_xfer = s2_valid && dout_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            xfer_count <= '0;
        end else if (out_xfer) begin
            xfer_count <= xfer_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_reversing_bits_pipe.sv
// ============================================================================
// tb_reversing_bits_pipe
// ----------------------------------------------------------------------------
// Directed and random stimulus for reversing_bits_pipe (DATA_WIDTH=32).
// The reference model uses streaming operators for the reverse rules and a
// word queue for ordering; directed tests also compare hand-computed values.
// Define REV_STATS_EN to exercise xfer_count (built with CNT_WIDTH=4).
// ============================================================================
module tb_reversing_bits_pipe;

    localparam int W = 32;
`ifdef REV_STATS_EN
    localparam int CW = 4;
`endif

    // ------------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         resetn = 1'b1;
    logic [W-1:0] din = '0;
    logic [1:0]   din_mode = 2'b00;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
`ifdef REV_STATS_EN
    logic [CW-1:0] xfer_count;
`endif

    always #5 clk = ~clk;

    reversing_bits_pipe #(
        .DATA_WIDTH(W)
`ifdef REV_STATS_EN
        ,
        .CNT_WIDTH(CW)
`endif
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .din_mode   (din_mode),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
`ifdef REV_STATS_EN
        ,
        .xfer_count (xfer_count)
`endif
    );

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           in_count = 0;
    int           out_count = 0;
    int           in_cyc_last = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] out_log[$];
    int           out_cyc[$];
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_dout = '0;
`ifdef REV_STATS_EN
    logic [CW-1:0] xfer_model = '0;
`endif

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference reverse rules, written with streaming operators.
    function automatic logic [W-1:0] model_rev(input logic [W-1:0] w, input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            2'b00:   r = {<<{w}};
            2'b01:   r = {<<4{w}};
            2'b10:   r = {<<8{w}};
            default: r = w;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Scoreboard / compare process (samples on the falling edge)
    // Occupancy is the number of accepted-but-not-emitted words; the block
    // holds at most two, so it must accept unless full and stalled.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            prev_stall = 1'b0;
            check("reset_dout_valid", 64'(dout_valid), 64'd0);
            check("reset_dout", 64'(dout), 64'd0);
`ifdef REV_STATS_EN
            xfer_model = '0;
            check("reset_xfer_count", 64'(xfer_count), 64'd0);
`endif
        end else begin
            check("din_ready", 64'(din_ready), 64'((exp_q.size() < 2) || dout_ready));
            if (exp_q.size() == 0) check("empty_dout_valid", 64'(dout_valid), 64'd0);
            if (exp_q.size() == 2) check("full_dout_valid", 64'(dout_valid), 64'd1);
            if (prev_stall) begin
                check("hold_dout_valid", 64'(dout_valid), 64'd1);
                check("hold_dout", 64'(dout), 64'(prev_dout));
            end
`ifdef REV_STATS_EN
            check("xfer_count", 64'(xfer_count), 64'(xfer_model));
`endif
            if (dout_valid && dout_ready) begin
                if (exp_q.size() > 0) check("dout", 64'(dout), 64'(exp_q.pop_front()));
                out_log.push_back(dout);
                out_cyc.push_back(cyc);
                out_count++;
`ifdef REV_STATS_EN
                xfer_model = xfer_model + 1'b1;
`endif
            end
            if (din_valid && din_ready) begin
                exp_q.push_back(model_rev(din, din_mode));
                in_cyc_last = cyc;
                in_count++;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks (inputs change 1ns after the rising edge)
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        tick();
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic [1:0] m, output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        din = d;
        din_mode = m;
        din_valid = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = din_ready;
            tick();
            waited++;
        end
        check("send_accepted", 64'(acc), 64'd1);
        din_valid = 1'b0;
        din = W'($urandom);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    task automatic clear_log();
        out_log.delete();
        out_cyc.delete();
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int w;
        int in_base;
        int out_base;
        bit rnd_done;

        // Reset state, checked directly while reset is held.
        #1 resetn = 1'b0;
        #2;
        check("t0_dout_valid", 64'(dout_valid), 64'd0);
        check("t0_dout", 64'(dout), 64'd0);
        check("t0_din_ready", 64'(din_ready), 64'd1);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        tick();

        // Bit reverse of 0x0000000B, latency 2 cycles after the offer cycle.
        dout_ready = 1'b1;
        clear_log();
        send_word(32'h0000000B, 2'b00, w);
        wait_drain();
        check("t1_count", 64'(out_log.size()), 64'd1);
        if (out_log.size() >= 1) begin
            check("t1_value", 64'(out_log[0]), 64'hD000_0000);
            check("t1_latency", 64'(out_cyc[0] - in_cyc_last), 64'd2);
        end

        // Back-to-back modes 01, 10, 11 on 0x12345678.
        clear_log();
        send_word(32'h12345678, 2'b01, w);
        check("t2_no_stall_0", 64'(w), 64'd1);
        send_word(32'h12345678, 2'b10, w);
        check("t2_no_stall_1", 64'(w), 64'd1);
        send_word(32'h12345678, 2'b11, w);
        check("t2_no_stall_2", 64'(w), 64'd1);
        wait_drain();
        check("t2_count", 64'(out_log.size()), 64'd3);
        if (out_log.size() >= 3) begin
            check("t2_nibble", 64'(out_log[0]), 64'h8765_4321);
            check("t2_byte", 64'(out_log[1]), 64'h7856_3412);
            check("t2_pass", 64'(out_log[2]), 64'h1234_5678);
            check("t2_consec_a", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
            check("t2_consec_b", 64'(out_cyc[2] - out_cyc[1]), 64'd1);
        end

        // Backpressure: four words offered continuously into a stalled sink.
        dout_ready = 1'b0;
        clear_log();
        in_base = in_count;
        fork
            begin
                int ww;
                send_word(32'h01020304, 2'b10, ww);
                send_word(32'hA5A5A5A5, 2'b11, ww);
                send_word(32'h80000001, 2'b00, ww);
                send_word(32'h0000ABCD, 2'b01, ww);
            end
            begin
                repeat (3) @(negedge clk);
                #1 check("t3_ready_3rd_offer", 64'(din_ready), 64'd0);
                repeat (3) @(negedge clk);
                #1;
                check("t3_accepted", 64'(in_count - in_base), 64'd2);
                check("t3_ready_held", 64'(din_ready), 64'd0);
                check("t3_dout_valid", 64'(dout_valid), 64'd1);
                check("t3_dout_first", 64'(dout), 64'h0403_0201);
                tick();
                dout_ready = 1'b1;
            end
        join
        wait_drain();
        check("t3_count", 64'(out_log.size()), 64'd4);
        if (out_log.size() >= 4) begin
            check("t3_w0", 64'(out_log[0]), 64'h0403_0201);
            check("t3_w1", 64'(out_log[1]), 64'hA5A5_A5A5);
            check("t3_w2", 64'(out_log[2]), 64'h8000_0001);
            check("t3_w3", 64'(out_log[3]), 64'hDCBA_0000);
        end

        // Reset with both stages full.
        dout_ready = 1'b0;
        send_word(32'h11223344, 2'b10, w);
        send_word(32'h55667788, 2'b00, w);
        check("t4_full_valid", 64'(dout_valid), 64'd1);
        check("t4_full_ready", 64'(din_ready), 64'd0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("t4_async_valid", 64'(dout_valid), 64'd0);
        check("t4_async_dout", 64'(dout), 64'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        #1;
        check("t4_ready_after", 64'(din_ready), 64'd1);
        check("t4_valid_after", 64'(dout_valid), 64'd0);
        tick();
        clear_log();
        dout_ready = 1'b1;
        repeat (5) tick();
        check("t4_no_stale", 64'(out_log.size()), 64'd0);
        send_word(32'hDEADBEEF, 2'b11, w);
        wait_drain();
        check("t4_count", 64'(out_log.size()), 64'd1);
        if (out_log.size() >= 1) check("t4_value", 64'(out_log[0]), 64'hDEAD_BEEF);

        // Random traffic against the model.
        in_base = in_count;
        out_base = out_count;
        rnd_done = 1'b0;
        fork
            begin
                int ww;
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send_word(W'($urandom), 2'($urandom_range(0, 3)), ww);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    dout_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        dout_ready = 1'b1;
        wait_drain();
        check("t5_in_count", 64'(in_count - in_base), 64'd1000);
        check("t5_out_count", 64'(out_count - out_base), 64'd1000);

`ifdef REV_STATS_EN
        // Counter wrap at CNT_WIDTH=4 and no counting while stalled.
        apply_reset();
        check("s_zero", 64'(xfer_count), 64'd0);
        rnd_done = 1'b0;
        fork
            begin
                int ww;
                for (int i = 0; i < 17; i++) send_word(W'(i), 2'b11, ww);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    dout_ready = ~dout_ready;
                    tick();
                end
            end
        join
        dout_ready = 1'b1;
        wait_drain();
        check("s_wrap", 64'(xfer_count), 64'd1);
        dout_ready = 1'b0;
        send_word(32'h0F0F0F0F, 2'b00, w);
        repeat (4) tick();
        check("s_stall_hold", 64'(xfer_count), 64'd1);
        dout_ready = 1'b1;
        wait_drain();
        check("s_after", 64'(xfer_count), 64'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
